// File: rtl/data_request_params.sv
// data_request_params: size encodings and lane helpers shared by the data request queue.
package data_request_params;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr);
        return size == SIZE_HALF ? addr[0] :
               size == SIZE_WORD ? |addr[1:0] :
               size == SIZE_DWORD ? |addr : 1'b0;
    endfunction

    // Helpers work at the widest bus; callers truncate to their own width.
    function automatic logic [63:0] replicate(input logic [1:0] size, input logic [63:0] data);
        return size == SIZE_BYTE ? {8{data[7:0]}} :
               size == SIZE_HALF ? {4{data[15:0]}} :
               size == SIZE_WORD ? {2{data[31:0]}} : data;
    endfunction

    function automatic logic [7:0] strobe(input logic [1:0] size, input logic [2:0] lane);
        return (size == SIZE_BYTE ? 8'h01 :
                size == SIZE_HALF ? 8'h03 :
                size == SIZE_WORD ? 8'h0f : 8'hff) << lane;
    endfunction

endpackage

// File: rtl/request_fifo.sv
// request_fifo: circular FIFO with wrap-bit pointers and a synchronous clear.
module request_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/data_request_queue.sv
// data_request_queue: buffers execute-stage memory requests, limits outstanding bus
// transactions and cancels responses belonging to flushed requests.
module data_request_queue
    import data_request_params::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_write,
    input  logic [1:0]              in_size,
    input  logic [31:0]             in_address,
    input  logic [DATA_WIDTH-1:0]   in_write_data,
    output logic                    in_address_error,
    input  logic                    flush,
    output logic                    data_ram_request,
    output logic                    data_ram_write,
    output logic [1:0]              data_ram_size,
    output logic [31:0]             data_ram_address,
    output logic [DATA_WIDTH-1:0]   data_ram_write_data,
    output logic [DATA_WIDTH/8-1:0] data_ram_write_strobe,
    input  logic                    data_ram_address_ready,
    input  logic                    data_ram_data_ok,
    input  logic [DATA_WIDTH-1:0]   data_ram_read_data,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_data
);
    localparam int STRB_W    = DATA_WIDTH/8;
    localparam int LANE_BITS = $clog2(STRB_W);
    localparam int ENTRY_W   = 1 + 2 + 32 + DATA_WIDTH + STRB_W;
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

    logic [2:0]            lane;
    logic [DATA_WIDTH-1:0] rep_data;
    logic [STRB_W-1:0]     rep_strobe, head_strobe;
    logic [ENTRY_W-1:0]    head;
    logic                  push, pop, full, empty, ok_cancel, ok_live;
    logic [OUT_W-1:0]      outstanding, out_upd;
    logic [7:0]            cancel_count, cancel_upd;

    assign lane       = 3'(in_address[LANE_BITS-1:0]);
    assign rep_data   = DATA_WIDTH'(replicate(in_size, 64'(in_write_data)));
    assign rep_strobe = in_write ? STRB_W'(strobe(in_size, lane)) : '0;

    assign in_address_error = in_valid && (misaligned(in_size, in_address[2:0]) ||
                              (in_size == SIZE_DWORD && DATA_WIDTH != 64));
    assign in_ready = !full && !flush && !reset;
    assign push     = in_valid && in_ready && !in_address_error;

    request_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data ({in_write, in_size, in_address, rep_data, rep_strobe}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign {data_ram_write, data_ram_size, data_ram_address, data_ram_write_data, head_strobe} = head;
    assign data_ram_request      = !empty && outstanding < OUT_W'(MAX_OUTSTANDING) && !flush;
    assign data_ram_write_strobe = data_ram_request ? head_strobe : '0;
    assign pop                   = data_ram_request && data_ram_address_ready;

    // Responses are in order, so cancelled ones always arrive before live ones.
    assign ok_cancel  = data_ram_data_ok && cancel_count != 0;
    assign ok_live    = data_ram_data_ok && cancel_count == 0 && outstanding != 0;
    assign out_upd    = outstanding + OUT_W'(pop) - OUT_W'(ok_live);
    assign cancel_upd = cancel_count - 8'(ok_cancel);
    assign resp_valid = ok_live && !flush && !reset;
    assign resp_data  = data_ram_read_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding  <= '0;
            cancel_count <= '0;
        end else if (flush) begin
            outstanding  <= '0;
            cancel_count <= cancel_upd + 8'(out_upd);
        end else begin
            outstanding  <= out_upd;
            cancel_count <= cancel_upd;
        end
    end

endmodule

// File: tb/tb_data_request_queue.sv
// tb_data_request_queue: directed checks of the data request queue on 32- and 64-bit buses.
module tb_data_request_queue;
    logic        clock = 0, reset = 1;
    logic        in_valid = 0, in_write = 0, flush = 0, ready = 0, data_ok = 0;
    logic [1:0]  in_size = 0;
    logic [31:0] in_address = 0, wdata = 0, rdata = 0;

    logic        in_ready, err, req, wr, rv;
    logic [1:0]  sz;
    logic [31:0] addr, wd, rd;
    logic [3:0]  strb;
    logic        in_ready64, err64, req64, wr64, rv64;
    logic [1:0]  sz64;
    logic [31:0] addr64;
    logic [63:0] wd64, rd64;
    logic [7:0]  strb64;

    int tests = 0, failed = 0;

    always #5 clock = ~clock;

    data_request_queue dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_write(in_write), .in_size(in_size), .in_address(in_address),
        .in_write_data(wdata), .in_address_error(err), .flush(flush),
        .data_ram_request(req), .data_ram_write(wr), .data_ram_size(sz),
        .data_ram_address(addr), .data_ram_write_data(wd), .data_ram_write_strobe(strb),
        .data_ram_address_ready(ready), .data_ram_data_ok(data_ok),
        .data_ram_read_data(rdata), .resp_valid(rv), .resp_data(rd)
    );

    data_request_queue #(.DATA_WIDTH(64)) dut64 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .in_write(in_write), .in_size(in_size), .in_address(in_address),
        .in_write_data({32'h0, wdata}), .in_address_error(err64), .flush(flush),
        .data_ram_request(req64), .data_ram_write(wr64), .data_ram_size(sz64),
        .data_ram_address(addr64), .data_ram_write_data(wd64), .data_ram_write_strobe(strb64),
        .data_ram_address_ready(ready), .data_ram_data_ok(data_ok),
        .data_ram_read_data({32'h0, rdata}), .resp_valid(rv64), .resp_data(rd64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1; in_write = w; in_size = s; in_address = a; wdata = d;
    endtask

    task automatic do_reset;
        reset = 1; in_valid = 0; flush = 0; data_ok = 0; ready = 0;
        tick;
        reset = 0;
        #1;
    endtask

    initial begin
        tick; tick;
        reset = 0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_request", req, 0);
        check("rst_resp_valid", rv, 0);
        check("rst_strobe", strb, 0);

        // store word, bus ready
        ready = 1;
        drive(1, 2, 32'h100, 32'h12345678);
        #1;
        check("sw_err", err, 0);
        check("sw_in_ready", in_ready, 1);
        tick;
        in_valid = 0;
        #1;
        check("sw_request", req, 1);
        check("sw_write", wr, 1);
        check("sw_address", addr, 32'h100);
        check("sw_size", sz, 2);
        check("sw_strobe", strb, 4'hf);
        check("sw_data", wd, 32'h12345678);
        tick;
        check("sw_popped", req, 0);
        data_ok = 1; rdata = 32'hcafef00d;
        #1;
        check("sw_resp_valid", rv, 1);
        check("sw_resp_data", rd, 32'hcafef00d);
        tick;
        data_ok = 0;

        // byte store lane replication and strobes
        do_reset;
        drive(1, 0, 32'h103, 32'hab);
        tick;
        in_valid = 0;
        #1;
        check("sb103_data", wd, 32'habababab);
        check("sb103_strobe", strb, 4'b1000);
        check("sb103_strobe64", strb64, 8'h08);
        do_reset;
        drive(1, 0, 32'h105, 32'hab);
        tick;
        in_valid = 0;
        #1;
        check("sb105_strobe", strb, 4'b0010);
        check("sb105_strobe64", strb64, 8'h20);
        check("sb105_data64", wd64, 64'habababababababab);

        // address errors
        do_reset;
        drive(0, 1, 32'h101, 0);
        #1;
        check("lh101_err", err, 1);
        check("lh101_in_ready", in_ready, 1);
        tick;
        in_valid = 0;
        #1;
        check("lh101_no_issue", req, 0);
        drive(0, 3, 32'h0, 0);
        #1;
        check("ld32_err", err, 1);
        check("ld64_err", err64, 0);
        drive(0, 0, 32'h103, 0);
        #1;
        check("lb103_err", err, 0);
        in_valid = 0;

        // fill, back-pressure, ordered drain and wrap
        do_reset;
        for (int i = 0; i < 5; i++) begin
            drive(0, 2, 32'h10 + 32'(4*i), 0);
            #1;
            check($sformatf("fill_in_ready%0d", i), in_ready, (i < 4) ? 1 : 0);
            tick;
        end
        in_valid = 0;
        #1;
        check("hold_request", req, 1);
        tick; tick;
        check("hold_address", addr, 32'h10);
        for (int j = 0; j < 4; j++) begin
            ready = 1;
            #1;
            check($sformatf("drain_req%0d", j), req, 1);
            check($sformatf("drain_addr%0d", j), addr, 32'h10 + 32'(4*j));
            tick;
            ready = 0; data_ok = 1;
            #1;
            check($sformatf("drain_resp%0d", j), rv, 1);
            tick;
            data_ok = 0;
        end
        #1;
        check("drain_empty", req, 0);
        drive(1, 2, 32'h40, 32'h77);
        tick;
        in_valid = 0;
        #1;
        check("wrap_req", req, 1);
        check("wrap_addr", addr, 32'h40);
        check("wrap_data", wd, 32'h77);

        // outstanding limit
        do_reset;
        ready = 1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 2, 32'h200 + 32'(4*i), 0);
            tick;
        end
        in_valid = 0;
        #1;
        check("lim_blocked", req, 0);
        check("lim_head", addr, 32'h208);
        tick;
        check("lim_still_blocked", req, 0);
        data_ok = 1; rdata = 32'h11;
        #1;
        check("lim_resp", rv, 1);
        check("lim_req_same_cycle", req, 0);
        tick;
        data_ok = 0;
        #1;
        check("lim_third_req", req, 1);
        check("lim_third_addr", addr, 32'h208);
        tick;

        // flush with two outstanding and one queued
        drive(0, 2, 32'h20c, 0);
        tick;
        in_valid = 0;
        #1;
        check("fl_pre_req", req, 0);
        flush = 1;
        drive(0, 2, 32'h400, 0);
        #1;
        check("fl_in_ready", in_ready, 0);
        check("fl_req", req, 0);
        tick;
        flush = 0; in_valid = 0;
        #1;
        check("fl_empty", req, 0);
        check("fl_in_ready_after", in_ready, 1);
        data_ok = 1;
        #1;
        check("fl_cancel1", rv, 0);
        tick;
        check("fl_cancel2", rv, 0);
        tick;
        data_ok = 0;
        drive(0, 2, 32'h300, 0);
        tick;
        in_valid = 0;
        #1;
        check("fl_new_req", req, 1);
        check("fl_new_addr", addr, 32'h300);
        tick;
        data_ok = 1; rdata = 32'h55aa;
        #1;
        check("fl_new_resp", rv, 1);
        check("fl_new_data", rd, 32'h55aa);
        tick;
        #1;
        check("stray_ok_ignored", rv, 0);
        tick;
        data_ok = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/data_request_queue.md
DATA_REQUEST_QUEUE -- requirements
Module: data_request_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width in bits (legal: 32, 64).
REQ-002 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, issued-but-unanswered request limit (1..15).
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 in_valid  in  1  request offered by execute stage.
REQ-007 in_ready  out  1  request accepted this cycle when in_valid&&in_ready.
REQ-008 in_write  in  1  1=store, 0=load.
REQ-009 in_size  in  2  log2 bytes (0=byte, 1=half, 2=word, 3=dword, 3 legal only if DATA_WIDTH=64).
REQ-010 in_address  in  32  byte address.
REQ-011 in_write_data  in  DATA_WIDTH  store data, low-aligned.
REQ-012 in_address_error  out  1  combinational: in_valid and address misaligned or in_size illegal.
REQ-013 flush  in  1  pipeline flush (exception/eret).
REQ-014 data_ram_request/write  out  1/1  bus request and direction.
REQ-015 data_ram_size  out  2  copy of queued in_size.
REQ-016 data_ram_address  out  32  queued address.
REQ-017 data_ram_write_data/write_strobe  out  DATA_WIDTH / DATA_WIDTH/8  lane-replicated data, byte strobes.
REQ-018 data_ram_address_ready  in  1  bus accepts request.
REQ-019 data_ram_data_ok / data_ram_read_data  in  1 / DATA_WIDTH  in-order response.
REQ-020 resp_valid / resp_data  out  1 / DATA_WIDTH  forwarded, non-cancelled response.

Function
REQ-021 in_ready SHALL equal !full && !flush && !reset; a request with in_address_error=1 SHALL NOT be enqueued.
REQ-022 Misaligned SHALL mean address[size-1:0]!=0 for size>=1; byte never misaligned.
REQ-023 Enqueued write data SHALL be replicated to every lane of 2^size bytes; strobe SHALL set the 2^size bits at lane address[log2(DATA_WIDTH/8)-1:0]; loads SHALL drive strobe 0.
REQ-024 FIFO SHALL be circular, pointers wrap DEPTH-1->0, full/empty via extra pointer bit; push and pop in same cycle SHALL keep occupancy, legal also when full (push accepted only if !full at cycle start).
REQ-025 data_ram_request SHALL equal !empty && outstanding<MAX_OUTSTANDING && !flush; head entry drives all data_ram_* outputs.
REQ-026 Pop SHALL occur on data_ram_request && data_ram_address_ready; outputs SHALL stay stable while request held without ready.
REQ-027 outstanding counter SHALL +1 on pop, -1 on data_ram_data_ok, both same cycle = unchanged; data_ok with outstanding=0 SHALL be ignored.
REQ-028 Response latency: resp_valid SHALL assert the same cycle as data_ram_data_ok (combinational) when cancel_count=0, resp_data=data_ram_read_data.
REQ-029 When cancel_count>0, data_ram_data_ok SHALL decrement cancel_count and resp_valid SHALL stay 0.
REQ-030 Flush SHALL empty FIFO next cycle and set cancel_count to outstanding+cancel_count after that cycle's pop/data_ok updates (responses arriving in flush cycle count as cancelled).
REQ-031 in_valid during flush SHALL be dropped; no request SHALL issue in flush cycle.

Reset
REQ-032 Reset SHALL clear pointers, outstanding, cancel_count; in following cycle in_ready=1, data_ram_request=0, resp_valid=0, strobe=0.
REQ-033 Reset mid-transaction SHALL discard queued and outstanding state; responses after reset with outstanding=0 ignored.

Structure
REQ-034 Size encodings and strobe/replication helper functions SHALL live in shared package data_request_params.
REQ-035 FIFO storage SHALL be sub-module request_fifo (parametrised width/depth); control in top.

Verification
REQ-036 Store word 0x12345678 @0x100, ready=1 -> next cycle request, strobe 4'b1111, data 0x12345678.
REQ-037 Store byte 0xAB @0x103 (32-bit) -> data 0xABABABAB, strobe 4'b1000; DATA_WIDTH=64 @0x105 -> strobe 8'h20.
REQ-038 Load half @0x101 -> in_address_error=1, in_ready unaffected, nothing issued.
REQ-039 DEPTH=4, ready=0, push 5 -> in_ready=0 after 4; raise ready -> 4 pops in order, wrap verified.
REQ-040 MAX_OUTSTANDING=2, 3 loads, no data_ok -> exactly 2 issue; one data_ok -> 3rd issues.
REQ-041 2 outstanding, flush with 1 queued -> FIFO empty, next 2 data_ok give resp_valid=0, 3rd load after flush returns resp_valid=1.
